// File: rtl/alu_control_memory_access.sv
// ALU function decode plus the memory-access stage: 64-bit data memory,
// writeback source select, branch resolution and pipeline register capture.
module alu_control_memory_access #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instruction,
    input  logic [1:0]  ALUOp,
    output logic [3:0]  ALUInstr,
    input  logic [63:0] branchAddress,
    input  logic [63:0] Results,
    input  logic [63:0] Data2,
    input  logic        zero,
    input  logic        B,
    input  logic        BZ,
    input  logic        BNZ,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    output logic [63:0] oldBranchAddress,
    output logic        PCSrc,
    output logic        oldRegWrite,
    output logic [63:0] Data2Write,
    output logic [4:0]  Reg2Write
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [63:0]   mem [MEM_WORDS];
    logic [AW-1:0] idx;
    logic [10:0]   opc;
    logic          unused_ok;

    assign opc = Instruction[31:21];
    // Byte offset and any bits above the memory depth are dropped, so addresses wrap.
    assign idx = Results[AW+2:3];
    // The read path is always live; MemRead carries no information here.
    assign unused_ok = ^{MemRead, Instruction[20:5], Results[63:AW+3], Results[2:0]};

    always_comb begin
        ALUInstr = 4'b1111;
        case (ALUOp)
            2'b00: ALUInstr = 4'b0010;
            2'b01: ALUInstr = 4'b0111;
            2'b10: begin
                case (opc)
                    11'b10001011000: ALUInstr = 4'b0010;
                    11'b11001011000: ALUInstr = 4'b0110;
                    11'b10001010000: ALUInstr = 4'b0000;
                    11'b10101010000: ALUInstr = 4'b0001;
                    default:         ALUInstr = 4'b1111;
                endcase
            end
            default: begin
                case (opc[10:1])
                    10'b1001000100: ALUInstr = 4'b0010;
                    10'b1101000100: ALUInstr = 4'b0110;
                    10'b1001001000: ALUInstr = 4'b0000;
                    10'b1011001000: ALUInstr = 4'b0001;
                    default:        ALUInstr = 4'b1111;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (MemWrite) begin
            mem[idx] <= Data2;
        end
    end

    // mem[idx] is sampled before this edge's write lands: read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oldBranchAddress <= '0;
            PCSrc            <= 1'b0;
            oldRegWrite      <= 1'b0;
            Data2Write       <= '0;
            Reg2Write        <= '0;
        end else begin
            oldBranchAddress <= branchAddress;
            PCSrc            <= B | (BZ & zero) | (BNZ & ~zero);
            oldRegWrite      <= RegWrite;
            Data2Write       <= MemToReg ? mem[idx] : Results;
            Reg2Write        <= Instruction[4:0];
        end
    end
endmodule

// File: tb/tb_alu_control_memory_access.sv
// Randomized self-checking bench for alu_control_memory_access against a
// word-array memory model and a table-driven ALU decode reference.
module tb_alu_control_memory_access;
    localparam int MW = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Instruction = '0;
    logic [1:0]  ALUOp = '0;
    logic [3:0]  ALUInstr;
    logic [63:0] branchAddress = '0, Results = '0, Data2 = '0;
    logic        zero = 0, B = 0, BZ = 0, BNZ = 0;
    logic        MemRead = 0, MemWrite = 0, MemToReg = 0, RegWrite = 0;
    logic [63:0] oldBranchAddress, Data2Write;
    logic        PCSrc, oldRegWrite;
    logic [4:0]  Reg2Write;

    int passed = 0, total = 0;
    logic [63:0] model [MW];

    alu_control_memory_access #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .ALUOp(ALUOp),
        .ALUInstr(ALUInstr), .branchAddress(branchAddress), .Results(Results),
        .Data2(Data2), .zero(zero), .B(B), .BZ(BZ), .BNZ(BNZ),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .oldBranchAddress(oldBranchAddress), .PCSrc(PCSrc),
        .oldRegWrite(oldRegWrite), .Data2Write(Data2Write), .Reg2Write(Reg2Write)
    );

    always #5 clk = ~clk;

    // Known mnemonic encodings and the ALU function each one selects.
    logic [10:0] r_opc [4] = '{11'h458, 11'h658, 11'h450, 11'h550};
    logic [9:0]  i_opc [4] = '{10'h244, 10'h344, 10'h248, 10'h2C8};
    logic [3:0]  fn    [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};

    function automatic logic [3:0] ref_alu(logic [1:0] op, logic [10:0] o);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0111;
        for (int k = 0; k < 4; k++) begin
            if (op == 2'b10 && o == r_opc[k]) return fn[k];
            if (op == 2'b11 && o[10:1] == i_opc[k]) return fn[k];
        end
        return 4'b1111;
    endfunction

    function automatic int word_of(logic [63:0] addr);
        return int'((addr / 8) % MW);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Instruction = '0; ALUOp = '0; branchAddress = '0; Results = '0; Data2 = '0;
        zero = 0; B = 0; BZ = 0; BNZ = 0;
        MemRead = 0; MemWrite = 0; MemToReg = 0; RegWrite = 0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({oldBranchAddress, PCSrc, oldRegWrite, Data2Write, Reg2Write} !== '0)
            $display("FAIL reset_outputs got %h/%b/%b/%h/%h want all 0",
                     oldBranchAddress, PCSrc, oldRegWrite, Data2Write, Reg2Write);
        else passed++;
        for (int i = 0; i < MW; i++) model[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_decode();
        logic [3:0] exp;
        ALUOp = 2'b10; Instruction = {11'b11001011000, 21'h0}; #1;
        total++; if (ALUInstr !== 4'b0110) $display("FAIL alu_sub got %b want 0110", ALUInstr); else passed++;
        ALUOp = 2'b00; Instruction = $urandom; #1;
        total++; if (ALUInstr !== 4'b0010) $display("FAIL alu_ldst got %b want 0010", ALUInstr); else passed++;
        ALUOp = 2'b10; Instruction = '0; #1;
        total++; if (ALUInstr !== 4'b1111) $display("FAIL alu_invalid got %b want 1111", ALUInstr); else passed++;
        for (int n = 0; n < 120; n++) begin
            ALUOp = 2'($urandom);
            Instruction = $urandom;
            if ($urandom_range(1, 0) == 1) begin
                int k = $urandom_range(3, 0);
                if (ALUOp == 2'b11) Instruction[31:22] = i_opc[k];
                else Instruction[31:21] = r_opc[k];
            end
            #1;
            exp = ref_alu(ALUOp, Instruction[31:21]);
            total++;
            if (ALUInstr !== exp)
                $display("FAIL alu_rand op=%b opc=%h got %b want %b", ALUOp, Instruction[31:21], ALUInstr, exp);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_mem_write_read();
        MemWrite = 1; Results = 64'h10; Data2 = 64'hDEADBEEF;
        tick(); model[word_of(64'h10)] = 64'hDEADBEEF;
        MemWrite = 0; MemToReg = 1; Results = 64'h10;
        tick();
        total++;
        if (Data2Write !== 64'hDEADBEEF) $display("FAIL mem_rw got %h want deadbeef", Data2Write); else passed++;
        idle_inputs();
    endtask

    task automatic test_writeback_regs();
        MemToReg = 0; Results = 64'h1234; Instruction = 32'd5; RegWrite = 1;
        tick();
        total++;
        if ({Data2Write, Reg2Write, oldRegWrite} !== {64'h1234, 5'd5, 1'b1})
            $display("FAIL wb_regs got %h/%0d/%b want 1234/5/1", Data2Write, Reg2Write, oldRegWrite);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_branch();
        logic exp;
        for (int c = 0; c < 16; c++) begin
            {B, BZ, BNZ, zero} = 4'(c);
            branchAddress = (c == 5) ? 64'h400 : {$urandom, $urandom};
            // Taken when unconditional, or the condition flavour matches the flag.
            exp = (B == 1) || (BZ == 1 && zero == 1) || (BNZ == 1 && zero == 0);
            begin
                logic [63:0] ba = branchAddress;
                tick();
                total++;
                if (PCSrc !== exp || oldBranchAddress !== ba)
                    $display("FAIL branch c=%0d got %b/%h want %b/%h", c, PCSrc, oldBranchAddress, exp, ba);
                else passed++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap_rbw();
        MemWrite = 1; Results = 64'h108; Data2 = 64'hA5A5_0001;
        tick(); model[word_of(64'h108)] = 64'hA5A5_0001;
        MemWrite = 0; MemToReg = 1; Results = 64'h8;
        tick();
        total++; if (Data2Write !== 64'hA5A5_0001) $display("FAIL wrap got %h want a5a50001", Data2Write); else passed++;
        MemWrite = 1; MemToReg = 1; Results = 64'h8; Data2 = 64'h5A5A_0002;
        tick(); model[1] = 64'h5A5A_0002;
        total++; if (Data2Write !== 64'hA5A5_0001) $display("FAIL rbw_old got %h want a5a50001", Data2Write); else passed++;
        MemWrite = 0;
        tick();
        total++; if (Data2Write !== 64'h5A5A_0002) $display("FAIL rbw_new got %h want 5a5a0002", Data2Write); else passed++;
        idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] e_d2w, e_ba;
        logic [4:0]  e_r;
        logic        e_pc, e_rw;
        for (int n = 0; n < 300; n++) begin
            Instruction = $urandom; ALUOp = 2'($urandom);
            branchAddress = {$urandom, $urandom}; Data2 = {$urandom, $urandom};
            Results = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) Results = 64'($urandom_range(MW * 8 - 1, 0));
            {zero, B, BZ, BNZ} = 4'($urandom);
            {MemRead, MemWrite, MemToReg, RegWrite} = 4'($urandom);
            e_d2w = MemToReg ? model[word_of(Results)] : Results;
            e_pc  = (B == 1) || (BZ == 1 && zero == 1) || (BNZ == 1 && zero == 0);
            e_ba = branchAddress; e_rw = RegWrite; e_r = Instruction[4:0];
            if (MemWrite) model[word_of(Results)] = Data2;
            tick();
            total++;
            if ({Data2Write, PCSrc, oldBranchAddress, oldRegWrite, Reg2Write} !== {e_d2w, e_pc, e_ba, e_rw, e_r})
                $display("FAIL rand n=%0d got %h/%b/%h/%b/%h want %h/%b/%h/%b/%h", n,
                         Data2Write, PCSrc, oldBranchAddress, oldRegWrite, Reg2Write,
                         e_d2w, e_pc, e_ba, e_rw, e_r);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            MemWrite = 1; Results = 64'(i * 8); Data2 = {$urandom, $urandom} | 64'h1;
            tick(); model[i] = Data2;
        end
        RegWrite = 1; B = 1; branchAddress = 64'hFFFF; Instruction = 32'h1F;
        MemToReg = 0; Results = 64'h77;
        tick();
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        total++;
        if ({oldBranchAddress, PCSrc, oldRegWrite, Data2Write, Reg2Write} !== '0)
            $display("FAIL reset_async got %h/%b/%b/%h/%h want all 0",
                     oldBranchAddress, PCSrc, oldRegWrite, Data2Write, Reg2Write);
        else passed++;
        for (int i = 0; i < MW; i++) model[i] = '0;
        MemWrite = 1; Results = 64'h18; Data2 = 64'hBAD;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            MemToReg = 1; Results = 64'(i * 8);
            tick();
            total++;
            if (Data2Write !== model[i]) $display("FAIL post_reset_read w=%0d got %h want %h", i, Data2Write, model[i]);
            else passed++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_decode();
        test_mem_write_read();
        test_writeback_regs();
        test_branch();
        test_wrap_rbw();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
